// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter:
//     - wb_state_t : arbiter FSM state (IDLE / LAST_A / LAST_B)
//     - RF_AW      : register address width (4)
//     - RF_DW      : register data width (16)
//     - rf_is_r0() : helper, true when an address selects register 0
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int unsigned RF_AW = 4;
  localparam int unsigned RF_DW = 16;

  // IDLE   : the previous cycle issued no grant
  // LAST_A : the previous grant went to source A (B has priority next)
  // LAST_B : the previous grant went to source B (A has priority next)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAST_A = 2'd1,
    LAST_B = 2'd2
  } wb_state_t;

  function automatic logic rf_is_r0(input logic [RF_AW-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant logic. Purely combinational: grants are issued
//   in the same cycle as the requests.
//   Ports:
//     rst    in  : synchronous reset level; forces both grants low
//     state  in  : arbiter FSM state (which source won last)
//     a_req  in  : source A request
//     b_req  in  : source B request
//     a_gnt  out : grant to source A
//     b_gnt  out : grant to source B (never high together with a_gnt)
// -----------------------------------------------------------------------------
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      rst,
  input  wb_state_t state,
  input  logic      a_req,
  input  logic      b_req,
  output logic      a_gnt,
  output logic      b_gnt
);

  logic b_has_prio;

  // B only gets priority immediately after an A grant; IDLE and LAST_B favour A.
  assign b_has_prio = (state == LAST_A);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      unique case ({a_req, b_req})
        2'b10:   a_gnt = 1'b1;
        2'b01:   b_gnt = 1'b1;
        2'b11: begin
          a_gnt = ~b_has_prio;
          b_gnt =  b_has_prio;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Arbitrates two writeback sources (A = ALU, B = load) onto the single
//   register-file write port. Grants are combinational; the winning
//   destination/data are registered and presented with wr=1 the next cycle.
//   Ports:
//     clk            in  : clock, rising edge
//     rst            in  : synchronous active-high reset
//     a_req/a_rd/a_data in : source A request, destination, data
//     b_req/b_rd/b_data in : source B request, destination, data
//     a_gnt, b_gnt   out : same-cycle grants (mutually exclusive)
//     Rd, RW, wr     out : registered register-file write port
//     wb_busy        out : some request is pending and not granted this cycle
//   Configuration:
//     RF_R0_ZERO_EN  : when defined, a granted write to register 0 still
//                      consumes its grant but produces no wr pulse.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [RF_AW-1:0] a_rd,
  input  logic [RF_DW-1:0] a_data,
  input  logic             b_req,
  input  logic [RF_AW-1:0] b_rd,
  input  logic [RF_DW-1:0] b_data,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic [RF_AW-1:0] Rd,
  output logic [RF_DW-1:0] RW,
  output logic             wr,
  output logic             wb_busy
);

  wb_state_t        state_q;
  wb_state_t        state_d;
  logic             any_gnt;
  logic [RF_AW-1:0] win_rd;
  logic [RF_DW-1:0] win_data;
  logic             win_wr;

  rr_arb2 u_arb (
    .rst   (rst),
    .state (state_q),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign any_gnt = a_gnt | b_gnt;
  assign wb_busy = (a_req & ~a_gnt) | (b_req & ~b_gnt);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state tracks the most recent winner; a cycle without a grant
  // returns to IDLE so A regains priority after any gap.
  always_comb begin
    state_d = IDLE;
    if (a_gnt) begin
      state_d = LAST_A;
    end else if (b_gnt) begin
      state_d = LAST_B;
    end
  end

  // Winner selection for the write-port register stage
  always_comb begin
    win_rd   = a_rd;
    win_data = a_data;
    if (b_gnt) begin
      win_rd   = b_rd;
      win_data = b_data;
    end
`ifdef RF_R0_ZERO_EN
    win_wr = any_gnt & ~rf_is_r0(win_rd);
`else
    win_wr = any_gnt;
`endif
  end

  // Write port: Rd/RW only change when a write is actually issued, so a
  // suppressed R0 write behaves like an idle cycle on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= 1'b0;
      Rd <= '0;
      RW <= '0;
    end else begin
      wr <= win_wr;
      if (win_wr) begin
        Rd <= win_rd;
        RW <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req;
  logic [3:0]  a_rd, b_rd;
  logic [15:0] a_data, b_data;
  logic        a_gnt, b_gnt, wr, wb_busy;
  logic [3:0]  Rd;
  logic [15:0] RW;

  logic [15:0] rf [16];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  regfile_wb_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .a_rd    (a_rd),
    .a_data  (a_data),
    .b_req   (b_req),
    .b_rd    (b_rd),
    .b_data  (b_data),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt),
    .Rd      (Rd),
    .RW      (RW),
    .wr      (wr),
    .wb_busy (wb_busy)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port
  always @(posedge clk) begin
    if (wr) rf[Rd] <= RW;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic [3:0] ard, input logic [15:0] ad,
                       input logic br, input logic [3:0] brd, input logic [15:0] bd);
    a_req = ar; a_rd = ard; a_data = ad;
    b_req = br; b_rd = brd; b_data = bd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst = 1'b1;
    drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd6, 16'h6666);
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    tick(); tick();
    check("rst_wr", wr, 0);
    check("rst_Rd", Rd, 0);
    check("rst_RW", RW, 0);
    rst = 1'b0;

    // Lone A request
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000);
    check("a1_a_gnt", a_gnt, 1);
    check("a1_b_gnt", b_gnt, 0);
    check("a1_busy", wb_busy, 0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    check("a1_wr", wr, 1);
    check("a1_Rd", Rd, 3);
    check("a1_RW", RW, 16'h1234);
    tick();
    check("idle_wr", wr, 0);
    check("idle_Rd_hold", Rd, 3);
    check("idle_RW_hold", RW, 16'h1234);

    // Continuous requests from IDLE alternate A,B,A,B
    drive(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      check("alt_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
      check("alt_b_gnt", b_gnt, (i % 2 == 0) ? 0 : 1);
      check("alt_busy", wb_busy, 1);
      tick();
      check("alt_wr", wr, 1);
      check("alt_Rd", Rd, (i % 2 == 0) ? 1 : 2);
      check("alt_RW", RW, (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
      #1;
    end
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    tick();
    check("alt_end_wr", wr, 0);

    // Same destination collision: A first, then B, B's data survives
    drive(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002);
    check("col_a_gnt", a_gnt, 1);
    check("col_busy", wb_busy, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h0002);
    check("col_RW_first", RW, 16'h0001);
    check("col_b_gnt", b_gnt, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    check("col_RW_second", RW, 16'h0002);
    check("col_wr", wr, 1);
    tick();
    check("col_R5", rf[5], 16'h0002);

    // Reset rising in the cycle A would be granted
    rst = 1'b1;
    drive(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'h0000);
    check("rgnt_a_gnt", a_gnt, 0);
    tick();
    check("rgnt_wr", wr, 0);
    check("rgnt_Rd", Rd, 0);
    check("rgnt_RW", RW, 0);
    rst = 1'b0;
    drive(1'b1, 4'd7, 16'h7777, 1'b1, 4'd8, 16'h8888);
    check("post_rst_a_gnt", a_gnt, 1);
    check("post_rst_b_gnt", b_gnt, 0);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    tick();
    check("post_rst_wr", wr, 0);

    // Write to register 0 from B
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF);
    check("r0_b_gnt", b_gnt, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
`ifdef RF_R0_ZERO_EN
    check("r0_wr", wr, 0);
`else
    check("r0_wr", wr, 1);
    check("r0_Rd", Rd, 0);
    check("r0_RW", RW, 16'hFFFF);
`endif
    tick();

    // Single B grant, 3 idle cycles, then both -> A first
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'h0909);
    check("gapb_b_gnt", b_gnt, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    check("gapb_Rd", Rd, 9);
    tick(); tick(); tick();
    drive(1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd11, 16'h0B0B);
    check("gapb_a_gnt", a_gnt, 1);
    check("gapb_b_gnt", b_gnt, 0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);

    // Single A grant, one idle cycle, then both -> A again (LAST_A forgotten)
    tick();
    drive(1'b1, 4'd12, 16'h0C0C, 1'b0, 4'd0, 16'h0000);
    check("gapa_a_gnt", a_gnt, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    tick();
    drive(1'b1, 4'd13, 16'h0D0D, 1'b1, 4'd14, 16'h0E0E);
    check("gapa_a_gnt2", a_gnt, 1);
    check("gapa_b_gnt2", b_gnt, 0);
    tick();
    drive(1'b0, 4'd13, 16'h0D0D, 1'b1, 4'd14, 16'h0E0E);
    check("gapa_Rd", Rd, 13);
    check("gapa_b_next", b_gnt, 1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    check("gapa_Rd_b", Rd, 14);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
